// File: rtl/id_stage_pipe_if.sv
// ID/EXE register outputs seen by the execute stage.
// master drives the bundle, slave consumes it.
interface id_stage_pipe_if #(
   parameter int DATA_W = 32
);
   logic              wb_en_o;
   logic              mem_r_en_o;
   logic              mem_w_en_o;
   logic              b_o;
   logic              s_o;
   logic [3:0]        exe_cmd_o;
   logic [DATA_W-1:0] val_rn_o;
   logic [DATA_W-1:0] val_rm_o;
   logic              imm_o;
   logic [11:0]       shift_operand_o;
   logic [23:0]       signed_imm_24_o;
   logic [3:0]        dest_o;
   logic [3:0]        src1_o;
   logic [3:0]        src2_o;
   logic [DATA_W-1:0] pc_o;
   logic              valid_o;

   modport master (
      output wb_en_o, mem_r_en_o, mem_w_en_o, b_o, s_o,
      output exe_cmd_o, val_rn_o, val_rm_o, imm_o,
      output shift_operand_o, signed_imm_24_o,
      output dest_o, src1_o, src2_o, pc_o, valid_o
   );

   modport slave (
      input wb_en_o, mem_r_en_o, mem_w_en_o, b_o, s_o,
      input exe_cmd_o, val_rn_o, val_rm_o, imm_o,
      input shift_operand_o, signed_imm_24_o,
      input dest_o, src1_o, src2_o, pc_o, valid_o
   );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage: ARM-subset decode, register file, condition check
// and the ID/EXE pipeline register with flush/stall/bubble handling.
module id_stage_pipe #(
   parameter int DATA_W    = 32,
   parameter int NUM_REGS  = 16,
   parameter int WB_BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instr_in,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              wb_en,
   input  logic [3:0]        wb_dest,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              hazard,
   input  logic              flush,
   input  logic              exe_stall,
   input  logic [3:0]        sr,
   output logic [3:0]        src1,
   output logic [3:0]        src2,
   output logic              two_src,
   output logic              rn_valid,
   id_stage_pipe_if.master   ex
);
   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
      logic              mem_w_en;
      logic              b;
      logic              s;
      logic [3:0]        exe_cmd;
      logic [DATA_W-1:0] val_rn;
      logic [DATA_W-1:0] val_rm;
      logic              imm;
      logic [11:0]       shift_operand;
      logic [23:0]       signed_imm_24;
      logic [3:0]        dest;
      logic [3:0]        src1;
      logic [3:0]        src2;
      logic [DATA_W-1:0] pc;
      logic              valid;
   } id_ex_t;

   logic [3:0]        cond;
   logic [1:0]        mode;
   logic              imm;
   logic              s_bit;
   logic [3:0]        opcode;
   logic              store;
   logic              cond_met;
   logic              dec_wb;
   logic              dec_mr;
   logic              dec_mw;
   logic              dec_b;
   logic              dec_s;
   logic [3:0]        dec_cmd;
   logic              go;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic [DATA_W-1:0] rf [NUM_REGS];
   id_ex_t            d;
   id_ex_t            q;

   assign cond   = instr_in[31:28];
   assign mode   = instr_in[27:26];
   assign imm    = instr_in[25];
   assign opcode = instr_in[24:21];
   assign s_bit  = instr_in[20];
   assign store  = (mode == 2'b01) & ~s_bit;

   assign src1     = instr_in[19:16];
   assign src2     = store ? instr_in[15:12] : instr_in[3:0];
   assign two_src  = ~imm | store;
   assign rn_valid = ~(((mode == 2'b00) &
                        ((opcode == 4'b1101) | (opcode == 4'b1111))) |
                       (instr_in == 32'hE000_0000));

   always_comb begin
      dec_wb  = 1'b0;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_b   = 1'b0;
      dec_s   = 1'b0;
      dec_cmd = 4'b0000;
      unique case (1'b1)
         (mode == 2'b00): begin
            dec_s  = s_bit;
            dec_wb = 1'b1;
            case (opcode)
               4'b1101: dec_cmd = 4'b0001;
               4'b1111: dec_cmd = 4'b1001;
               4'b0100: dec_cmd = 4'b0010;
               4'b0101: dec_cmd = 4'b0011;
               4'b0010: dec_cmd = 4'b0100;
               4'b0110: dec_cmd = 4'b0101;
               4'b0000: dec_cmd = 4'b0110;
               4'b1100: dec_cmd = 4'b0111;
               4'b0001: dec_cmd = 4'b1000;
               4'b1010: begin
                  dec_cmd = 4'b0100;
                  dec_wb  = 1'b0;
               end
               4'b1000: begin
                  dec_cmd = 4'b0110;
                  dec_wb  = 1'b0;
               end
               default: begin
                  dec_wb = 1'b0;
                  dec_s  = 1'b0;
               end
            endcase
         end
         (mode == 2'b01): begin
            dec_cmd = 4'b0010;
            dec_wb  = s_bit;
            dec_mr  = s_bit;
            dec_mw  = ~s_bit;
         end
         (mode == 2'b10): dec_b = 1'b1;
         default: ;
      endcase
   end

   // sr = {N,Z,C,V}
   always_comb begin
      cond_met = 1'b0;
      case (cond)
         4'h0: cond_met = sr[2];
         4'h1: cond_met = ~sr[2];
         4'h2: cond_met = sr[1];
         4'h3: cond_met = ~sr[1];
         4'h4: cond_met = sr[3];
         4'h5: cond_met = ~sr[3];
         4'h6: cond_met = sr[0];
         4'h7: cond_met = ~sr[0];
         4'h8: cond_met = sr[1] & ~sr[2];
         4'h9: cond_met = ~sr[1] | sr[2];
         4'hA: cond_met = sr[3] == sr[0];
         4'hB: cond_met = sr[3] != sr[0];
         4'hC: cond_met = ~sr[2] & (sr[3] == sr[0]);
         4'hD: cond_met = sr[2] | (sr[3] != sr[0]);
         4'hE: cond_met = 1'b1;
         default: cond_met = 1'b0;
      endcase
   end

   always_comb begin
      rd1 = '0;
      if (int'(src1) < NUM_REGS) begin
         rd1 = rf[src1[AW-1:0]];
         if ((WB_BYPASS != 0) && wb_en && (wb_dest == src1))
            rd1 = wb_data;
      end
   end

   always_comb begin
      rd2 = '0;
      if (int'(src2) < NUM_REGS) begin
         rd2 = rf[src2[AW-1:0]];
         if ((WB_BYPASS != 0) && wb_en && (wb_dest == src2))
            rd2 = wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            rf[i] <= '0;
      end else if (wb_en && (int'(wb_dest) < NUM_REGS)) begin
         rf[wb_dest[AW-1:0]] <= wb_data;
      end
   end

   assign go = instr_valid & cond_met & ~hazard;

   always_comb begin
      d               = '0;
      d.wb_en         = go & dec_wb;
      d.mem_r_en      = go & dec_mr;
      d.mem_w_en      = go & dec_mw;
      d.b             = go & dec_b;
      d.s             = go & dec_s;
      d.exe_cmd       = go ? dec_cmd : 4'b0000;
      d.val_rn        = rd1;
      d.val_rm        = rd2;
      d.imm           = imm;
      d.shift_operand = instr_in[11:0];
      d.signed_imm_24 = instr_in[23:0];
      d.dest          = instr_in[15:12];
      d.src1          = src1;
      d.src2          = src2;
      d.pc            = pc_in;
      d.valid         = instr_valid & ~hazard;
   end

   // flush beats stall; stall holds the whole bundle
   always_ff @(posedge clk) begin
      if (!rst || flush)
         q <= '0;
      else if (!exe_stall)
         q <= d;
   end

   assign ex.wb_en_o         = q.wb_en;
   assign ex.mem_r_en_o      = q.mem_r_en;
   assign ex.mem_w_en_o      = q.mem_w_en;
   assign ex.b_o             = q.b;
   assign ex.s_o             = q.s;
   assign ex.exe_cmd_o       = q.exe_cmd;
   assign ex.val_rn_o        = q.val_rn;
   assign ex.val_rm_o        = q.val_rm;
   assign ex.imm_o           = q.imm;
   assign ex.shift_operand_o = q.shift_operand;
   assign ex.signed_imm_24_o = q.signed_imm_24;
   assign ex.dest_o          = q.dest;
   assign ex.src1_o          = q.src1;
   assign ex.src2_o          = q.src2;
   assign ex.pc_o            = q.pc;
   assign ex.valid_o         = q.valid;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus random traffic
// against a table-driven reference of the decode stage.
module tb_id_stage_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr_in;
   logic        instr_valid;
   logic [31:0] pc_in;
   logic        wb_en;
   logic [3:0]  wb_dest;
   logic [31:0] wb_data;
   logic        hazard;
   logic        flush;
   logic        exe_stall;
   logic [3:0]  sr;
   logic [3:0]  src1_a, src2_a, src1_b, src2_b;
   logic        two_src_a, rn_valid_a, two_src_b, rn_valid_b;

   id_stage_pipe_if #(.DATA_W(32)) ia ();
   id_stage_pipe_if #(.DATA_W(32)) ib ();

   id_stage_pipe #(.DATA_W(32), .NUM_REGS(16), .WB_BYPASS(1)) u_a (
      .clk(clk), .rst(rst), .instr_in(instr_in),
      .instr_valid(instr_valid), .pc_in(pc_in),
      .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
      .hazard(hazard), .flush(flush), .exe_stall(exe_stall),
      .sr(sr), .src1(src1_a), .src2(src2_a),
      .two_src(two_src_a), .rn_valid(rn_valid_a), .ex(ia)
   );

   id_stage_pipe #(.DATA_W(32), .NUM_REGS(8), .WB_BYPASS(0)) u_b (
      .clk(clk), .rst(rst), .instr_in(instr_in),
      .instr_valid(instr_valid), .pc_in(pc_in),
      .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
      .hazard(hazard), .flush(flush), .exe_stall(exe_stall),
      .sr(sr), .src1(src1_b), .src2(src2_b),
      .two_src(two_src_b), .rn_valid(rn_valid_b), .ex(ib)
   );

   always #5 clk = ~clk;

   wire [154:0] got_a = {ia.wb_en_o, ia.mem_r_en_o, ia.mem_w_en_o,
      ia.b_o, ia.s_o, ia.exe_cmd_o, ia.val_rn_o, ia.val_rm_o,
      ia.imm_o, ia.shift_operand_o, ia.signed_imm_24_o, ia.dest_o,
      ia.src1_o, ia.src2_o, ia.pc_o, ia.valid_o};
   wire [154:0] got_b = {ib.wb_en_o, ib.mem_r_en_o, ib.mem_w_en_o,
      ib.b_o, ib.s_o, ib.exe_cmd_o, ib.val_rn_o, ib.val_rm_o,
      ib.imm_o, ib.shift_operand_o, ib.signed_imm_24_o, ib.dest_o,
      ib.src1_o, ib.src2_o, ib.pc_o, ib.valid_o};

   logic [31:0]  mrf_a [16];
   logic [31:0]  mrf_b [8];
   logic [154:0] exp_a, exp_b;
   int           n_chk = 0;
   int           n_pass = 0;

   task automatic chk(string tag, logic [159:0] got, logic [159:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Conditions come in complementary pairs: odd code inverts even code.
   function automatic logic cond_ok(logic [3:0] c, logic [3:0] f);
      logic n, z, cy, v, base;
      {n, z, cy, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? ~base : base;
   endfunction

   // {wb, mem_r, mem_w, b, s, cmd[3:0]}
   function automatic logic [8:0] ctrl_of(logic [31:0] ins);
      logic [4:0] t;
      case (ins[27:26])
         2'b00: begin
            case (ins[24:21])
               4'b1101: t = 5'b1_0001;
               4'b1111: t = 5'b1_1001;
               4'b0100: t = 5'b1_0010;
               4'b0101: t = 5'b1_0011;
               4'b0010: t = 5'b1_0100;
               4'b0110: t = 5'b1_0101;
               4'b0000: t = 5'b1_0110;
               4'b1100: t = 5'b1_0111;
               4'b0001: t = 5'b1_1000;
               4'b1010: t = 5'b0_0100;
               4'b1000: t = 5'b0_0110;
               default: return 9'd0;
            endcase
            return {t[4], 3'b000, ins[20], t[3:0]};
         end
         2'b01: return ins[20] ? 9'b1_1000_0010 : 9'b0_0100_0010;
         2'b10: return 9'b0_0010_0000;
         default: return 9'd0;
      endcase
   endfunction

   function automatic logic is_str(logic [31:0] ins);
      return (ins[27:26] == 2'b01) && !ins[20];
   endfunction

   function automatic logic [3:0] idx2(logic [31:0] ins);
      return is_str(ins) ? ins[15:12] : ins[3:0];
   endfunction

   function automatic logic [31:0] read_a(logic [3:0] i);
      if (wb_en && wb_dest == i) return wb_data;
      return mrf_a[i];
   endfunction

   function automatic logic [31:0] read_b(logic [3:0] i);
      if (i >= 4'd8) return 32'd0;
      return mrf_b[i[2:0]];
   endfunction

   function automatic logic [154:0] next_of(logic [154:0] cur,
                                            logic [31:0] r1,
                                            logic [31:0] r2);
      logic [8:0] c;
      if (!rst || flush) return '0;
      if (exe_stall) return cur;
      c = (instr_valid && !hazard && cond_ok(instr_in[31:28], sr)) ?
          ctrl_of(instr_in) : 9'd0;
      return {c, r1, r2, instr_in[25], instr_in[11:0], instr_in[23:0],
              instr_in[15:12], instr_in[19:16], idx2(instr_in), pc_in,
              instr_valid & ~hazard};
   endfunction

   // One clock: check comb outputs, advance reference, check registers.
   task automatic cycle();
      logic [154:0] na, nb;
      logic [3:0]   s1, s2;
      logic         mov;
      #1;
      s1  = instr_in[19:16];
      s2  = idx2(instr_in);
      mov = (instr_in[27:26] == 2'b00) &&
            (instr_in[24:21] == 4'b1101 || instr_in[24:21] == 4'b1111);
      chk("comb", {src1_a, src2_a, two_src_a, rn_valid_a},
          {s1, s2, ~instr_in[25] | is_str(instr_in),
           ~(mov || instr_in == 32'hE000_0000)});
      na = next_of(exp_a, read_a(s1), read_a(s2));
      nb = next_of(exp_b, read_b(s1), read_b(s2));
      if (!rst) begin
         for (int i = 0; i < 16; i++) mrf_a[i] = '0;
         for (int i = 0; i < 8; i++) mrf_b[i] = '0;
      end else if (wb_en) begin
         mrf_a[wb_dest] = wb_data;
         if (wb_dest < 4'd8) mrf_b[wb_dest[2:0]] = wb_data;
      end
      @(posedge clk);
      #1;
      exp_a = na;
      exp_b = nb;
      chk("regs_a", got_a, exp_a);
      chk("regs_b", got_b, exp_b);
   endtask

   task automatic idle();
      rst = 1'b1; instr_in = '0; instr_valid = 1'b0; pc_in = '0;
      wb_en = 1'b0; wb_dest = '0; wb_data = '0;
      hazard = 1'b0; flush = 1'b0; exe_stall = 1'b0; sr = 4'h0;
   endtask

   task automatic wr(logic [3:0] i, logic [31:0] v);
      idle();
      wb_en = 1'b1; wb_dest = i; wb_data = v;
      cycle();
   endtask

   task automatic issue(logic [31:0] ins);
      idle();
      instr_in = ins; instr_valid = 1'b1; pc_in = $urandom;
   endtask

   logic [154:0] hold;

   initial begin
      exp_a = '0;
      exp_b = '0;
      for (int i = 0; i < 16; i++) mrf_a[i] = '0;
      for (int i = 0; i < 8; i++) mrf_b[i] = '0;

      issue($urandom);
      rst = 1'b0;
      cycle();
      chk("rst_a", got_a, 155'd0);
      chk("rst_b", got_b, 155'd0);

      for (int i = 0; i < 16; i++) begin
         issue(32'hE080_0000 | (i << 16) | i);
         cycle();
         chk("rf_zero", ia.val_rn_o, 32'd0);
      end

      wr(4'd2, 32'd5);
      wr(4'd3, 32'd7);
      issue(32'hE082_1003);
      cycle();
      chk("add_cmd", ia.exe_cmd_o, 4'b0010);
      chk("add_wb", ia.wb_en_o, 1'b1);
      chk("add_rn", ia.val_rn_o, 32'd5);
      chk("add_rm", ia.val_rm_o, 32'd7);
      chk("add_dest", ia.dest_o, 4'd1);
      chk("add_2src", two_src_a, 1'b1);

      issue(32'hE082_1003);
      wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'h55;
      cycle();
      chk("byp_on", ia.val_rn_o, 32'h55);
      chk("byp_off", ib.val_rn_o, 32'd5);

      wr(4'd2, 32'd5);
      issue(32'h0082_1003);
      sr = 4'b0000;
      cycle();
      chk("eq_fail_ctl", got_a[154:146], 9'd0);
      chk("eq_fail_rn", ia.val_rn_o, 32'd5);
      chk("eq_fail_dest", ia.dest_o, 4'd1);
      sr = 4'b0100;
      cycle();
      chk("eq_pass_wb", ia.wb_en_o, 1'b1);

      hold = exp_a;
      issue($urandom);
      exe_stall = 1'b1;
      cycle();
      cycle();
      chk("stall_hold", got_a, hold);

      issue(32'hE082_1003);
      hazard = 1'b1;
      cycle();
      chk("haz_ctl", got_a[154:146], 9'd0);
      chk("haz_valid", ia.valid_o, 1'b0);
      chk("haz_rn", ia.val_rn_o, 32'd5);

      issue(32'hE082_1003);
      flush = 1'b1; exe_stall = 1'b1;
      cycle();
      chk("flush_stall", got_a, 155'd0);

      wr(4'd1, 32'd9);
      wr(4'd2, 32'd4);
      issue(32'hE582_1000);
      cycle();
      chk("str_src2", src2_a, 4'd1);
      chk("str_2src", two_src_a, 1'b1);
      chk("str_mw", ia.mem_w_en_o, 1'b1);
      chk("str_wb", ia.wb_en_o, 1'b0);
      chk("str_rm", ia.val_rm_o, 32'd9);

      wr(4'd12, 32'h77);
      issue(32'hE08C_0000);
      cycle();
      chk("r12_small", ib.val_rn_o, 32'd0);
      chk("r12_full", ia.val_rn_o, 32'h77);

      for (int k = 0; k < 400; k++) begin
         idle();
         instr_in = $urandom;
         if ($urandom_range(1, 0) == 1) instr_in[31:28] = 4'hE;
         if ($urandom_range(3, 0) != 0) instr_in[27:26] = 2'($urandom_range(1, 0));
         if ($urandom_range(19, 0) == 0) instr_in = 32'hE000_0000;
         instr_valid = ($urandom_range(9, 0) != 0);
         pc_in       = $urandom;
         wb_en       = $urandom_range(1, 0) == 1;
         wb_dest     = 4'($urandom);
         wb_data     = $urandom;
         hazard      = ($urandom_range(9, 0) == 0);
         flush       = ($urandom_range(19, 0) == 0);
         exe_stall   = ($urandom_range(6, 0) == 0);
         rst         = ($urandom_range(39, 0) != 0);
         sr          = 4'($urandom);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised decode stage with its ID/EXE pipeline register built in. It decodes the ARM-subset instruction, reads a parametrised register file with optional write-back bypass, and evaluates the condition code against the status register. Hazard bubbles, flush and hold (stall) are resolved inside the block. Downstream EXE logic sees only registered outputs; hazard and forwarding logic see combinational source fields.

Parameters:
DATA_W, 32, register and datapath width
NUM_REGS, 16, implemented registers (2..16); a read of an index >= NUM_REGS returns 0, and a write to such an index is ignored
WB_BYPASS, 1, 1 = a same-cycle write-back is visible on the read ports; 0 = the stored value is read

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
instr_in  in  32  instruction from IF register
instr_valid  in  1  instr_in holds a real instruction
pc_in  in  DATA_W  PC of instr_in
wb_en  in  1  register-file write enable
wb_dest  in  4  write index
wb_data  in  DATA_W  write data
hazard  in  1  insert bubble (from hazard unit)
flush  in  1  clear ID/EXE register (taken branch)
exe_stall  in  1  hold ID/EXE register
sr  in  4  status {N,Z,C,V} = sr[3:0]
src1, src2  out  4  combinational: src1 = Rn; src2 = Rd when the instruction is a store, else Rm
two_src  out  1  combinational: ~I | store
rn_valid  out  1  combinational: 0 for MOV, MVN and all-zero-operand NOP (0xE0000000), else 1
wb_en_o, mem_r_en_o, mem_w_en_o, b_o, s_o  out  1 each  registered control
exe_cmd_o  out  4  registered ALU command
val_rn_o, val_rm_o  out  DATA_W  registered operands
imm_o  out  1  registered I bit
shift_operand_o  out  12  registered
signed_imm_24_o  out  24  registered
dest_o, src1_o, src2_o  out  4 each  registered indices
pc_o  out  DATA_W  registered PC
valid_o  out  1  registered instr_valid & ~hazard

Behaviour:
- Instruction fields: cond [31:28], mode [27:26], I [25], opcode [24:21], S [20], Rn [19:16], Rd [15:12], Rm [3:0].
- Decode for mode 00, giving EXE_CMD and wb_en:
  - MOV 1101 -> 0001; MVN 1111 -> 1001; ADD 0100 -> 0010; ADC 0101 -> 0011.
  - SUB 0010 -> 0100; SBC 0110 -> 0101; AND 0000 -> 0110; ORR 1100 -> 0111; EOR 0001 -> 1000.
  - All of the above set wb_en = 1.
  - CMP 1010 -> 0100 and TST 1000 -> 0110, both with wb_en = 0.
  - s_o = S for mode 00; any other opcode decodes as all-zero control.
- Decode for mode 01:
  - S = 1 is LDR: wb, mem_r, EXE 0010.
  - S = 0 is STR: mem_w, EXE 0010.
  - s_o = 0.
- Decode for mode 10: b_o = 1 and all other control is 0. Mode 11 decodes as all-zero control.
- Condition codes: EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1; 1111 never.
- Register file:
  - NUM_REGS x DATA_W, written at posedge when wb_en = 1.
  - Two combinational read ports, src1 and src2.
  - Bypass (WB_BYPASS = 1): if wb_en = 1 and wb_dest equals a read index below NUM_REGS, that read port returns wb_data.
  - rst = 0 at posedge clears all registers to 0.
- ID/EXE register update at posedge, priority order:
  1. rst = 0: all registered outputs become 0.
  2. flush = 1: all registered outputs become 0 (bubble).
  3. exe_stall = 1: all registered outputs hold.
  4. Otherwise load.
- On load, the control fields (wb, mem_r, mem_w, b, s, exe_cmd) take the decoded values only when instr_valid & cond_met & ~hazard; otherwise they load 0.
- On load, the data fields (operands, imm, shift, imm24, dest, src1/src2, pc) always load.
- Latency: 1 cycle from instr_in to the registered outputs.
- flush and exe_stall asserted together: flush wins.
- A register-file write during exe_stall still occurs. The held val_rn_o / val_rm_o do not refresh; forwarding handles that case.
- Reset mid-operation: outputs are 0 on the next cycle and the register file is cleared; combinational outputs follow instr_in unaffected.

Test Plan:
1. Reset: hold rst = 0 for 1 cycle with an arbitrary instr_in -> all registered outputs 0; reading R0..R15 returns 0.
2. ADD: preload R2 = 5, R3 = 7, then apply 0xE0821003 -> next cycle exe_cmd_o = 0010, wb_en_o = 1, val_rn_o = 5, val_rm_o = 7, dest_o = 1, two_src = 1.
3. Bypass: apply wb_en = 1, wb_dest = 2, wb_data = 0x55 in the same cycle as decoding ADD R1,R2,R3 -> val_rn_o = 0x55 (WB_BYPASS = 1); with WB_BYPASS = 0 -> val_rn_o = 5.
4. Condition fail: ADDEQ (0x00821003) with sr = 0000 -> all control outputs 0, val_rn_o = 5, dest_o = 1; with sr = 0100 -> wb_en_o = 1.
5. Stall/flush/hazard:
   - exe_stall = 1 for 2 cycles -> outputs unchanged.
   - hazard = 1 -> control 0 and valid_o = 0.
   - flush = 1 with exe_stall = 1 -> all outputs 0.
6. STR (0xE5821000), R1 = 9, R2 = 4 -> src2 = 1, two_src = 1, mem_w_en_o = 1, wb_en_o = 0, val_rm_o = 9; with NUM_REGS = 8, reading R12 -> 0.
